// File: rtl/torus_vc_port.sv
// Torus router port: one FIFO per virtual channel, with round-robin selection of the output VC.
// Per-VC backpressure is applied in both directions, and a sticky completion flag is raised after N_PACKETS flits have left.
module torus_vc_port #(
    parameter int X_W       = 2,
    parameter int Y_W       = 2,
    parameter int D_W       = 256,
    parameter int VC_W      = 1,
    parameter int DEPTH     = 4,
    parameter int N_PACKETS = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_v,
    input  logic [VC_W-1:0]        in_vc,
    input  logic [X_W-1:0]         in_x,
    input  logic [Y_W-1:0]         in_y,
    input  logic [D_W-1:0]         in_data,
    output logic [(1<<VC_W)-1:0]   in_b,
    output logic                   out_v,
    output logic [VC_W-1:0]        out_vc,
    output logic [X_W-1:0]         out_x,
    output logic [Y_W-1:0]         out_y,
    output logic [D_W-1:0]         out_data,
    input  logic [(1<<VC_W)-1:0]   out_b,
    output logic                   err_ovf,
    output logic                   done
);

    localparam int NUM_VC = 1 << VC_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int POP_W  = $clog2(N_PACKETS) + 1;
    localparam int F_W    = X_W + Y_W + D_W;

    logic [F_W-1:0]    mem [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  count [NUM_VC];
    logic [VC_W-1:0]   rr_ptr;
    logic [VC_W-1:0]   sel_vc;
    logic [VC_W-1:0]   cand;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] push_vc;
    logic [NUM_VC-1:0] pop_vc;
    logic              push;
    logic              pop;
    logic              all_empty;
    logic [POP_W-1:0]  pop_cnt;

    always_comb begin
        in_b      = '0;
        eligible  = '0;
        all_empty = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            in_b[v]     = (count[v] == CNT_W'(DEPTH));
            eligible[v] = (count[v] != '0) && !out_b[v];
            if (count[v] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    assign push = in_v && !in_b[in_vc];

    // Round-robin selection: the first eligible VC at or after rr_ptr wins.
    // The loop runs downwards so that the smallest offset is assigned last and therefore takes priority.
    always_comb begin
        sel_vc = rr_ptr;
        cand   = rr_ptr;
        out_v  = 1'b0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            cand = rr_ptr + VC_W'(i);
            if (eligible[cand]) begin
                sel_vc = cand;
                out_v  = 1'b1;
            end
        end
    end

    assign pop    = out_v;
    assign out_vc = sel_vc;
    assign {out_x, out_y, out_data} = mem[sel_vc][rd_ptr[sel_vc]];

    always_comb begin
        push_vc         = '0;
        pop_vc          = '0;
        push_vc[in_vc]  = push;
        pop_vc[sel_vc]  = pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[in_vc][wr_ptr[in_vc]] <= {in_x, in_y, in_data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // A push and a pop on the same VC in one cycle leave its count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_vc[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
                end
                if (pop_vc[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
                end
                case ({push_vc[v], pop_vc[v]})
                    2'b10:   count[v] <= count[v] + CNT_W'(1);
                    2'b01:   count[v] <= count[v] - CNT_W'(1);
                    default: count[v] <= count[v];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            pop_cnt <= '0;
            err_ovf <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (pop) begin
                rr_ptr <= sel_vc + VC_W'(1);
            end
            if (pop && (pop_cnt != '1)) begin
                pop_cnt <= pop_cnt + POP_W'(1);
            end
            if (in_v && in_b[in_vc]) begin
                err_ovf <= 1'b1;
            end
            if ((pop_cnt == POP_W'(N_PACKETS)) && all_empty) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_torus_vc_port.sv
// Scoreboard bench for torus_vc_port: per-VC queues of expected flits, driven by random and directed traffic.
// A negedge monitor compares the DUT's outputs against the queue-based reference model.
module tb_torus_vc_port;

    localparam int X_W       = 2;
    localparam int Y_W       = 2;
    localparam int D_W       = 256;
    localparam int VC_W      = 1;
    localparam int DEPTH     = 4;
    localparam int N_PACKETS = 8;
    localparam int NUM_VC    = 1 << VC_W;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] data;
    } flit_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_v = 1'b0;
    logic [VC_W-1:0]   in_vc = '0;
    logic [X_W-1:0]    in_x = '0;
    logic [Y_W-1:0]    in_y = '0;
    logic [D_W-1:0]    in_data = '0;
    logic [NUM_VC-1:0] in_b;
    logic              out_v;
    logic [VC_W-1:0]   out_vc;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    logic [D_W-1:0]    out_data;
    logic [NUM_VC-1:0] out_b = '0;
    logic              err_ovf;
    logic              done;

    flit_t sb [NUM_VC][$];
    int    vectors = 0;
    int    miscompares = 0;
    int    m_rr = 0;
    int    m_pops = 0;
    bit    m_err = 0;
    bit    m_done = 0;
    bit    pend_pop = 0;
    int    pend_vc = 0;
    bit    mon_any;
    int    mon_sel;
    bit    cm_empty;
    bit    cm_drop;

    torus_vc_port #(
        .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .VC_W(VC_W), .DEPTH(DEPTH), .N_PACKETS(N_PACKETS)
    ) dut (
        .clk(clk), .rst(rst),
        .in_v(in_v), .in_vc(in_vc), .in_x(in_x), .in_y(in_y), .in_data(in_data),
        .in_b(in_b),
        .out_v(out_v), .out_vc(out_vc), .out_x(out_x), .out_y(out_y), .out_data(out_data),
        .out_b(out_b),
        .err_ovf(err_ovf), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [D_W-1:0] act, input logic [D_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_t mkFlit(input int x, input int y, input logic [D_W-1:0] d);
        flit_t f;
        f.x    = X_W'(x);
        f.y    = Y_W'(y);
        f.data = d;
        return f;
    endfunction

    function automatic flit_t randFlit();
        flit_t f;
        f.x = X_W'($urandom());
        f.y = Y_W'($urandom());
        for (int k = 0; k < D_W; k += 32) begin
            f.data[k +: 32] = $urandom();
        end
        return f;
    endfunction

    // Monitor: works out the expected outputs from the model's queue occupancy and arbitration pointer.
    always @(negedge clk) begin
        if (!rst) begin
            pend_pop = 0;
            checkOutput("reset out_v", out_v, 0);
            checkOutput("reset in_b", in_b, 0);
            checkOutput("reset err_ovf", err_ovf, 0);
            checkOutput("reset done", done, 0);
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                checkOutput("in_b", in_b[v], sb[v].size() == DEPTH);
            end
            mon_any = 0;
            mon_sel = 0;
            for (int i = 0; i < NUM_VC; i++) begin
                if (!mon_any && sb[(m_rr + i) % NUM_VC].size() > 0 && !out_b[(m_rr + i) % NUM_VC]) begin
                    mon_any = 1;
                    mon_sel = (m_rr + i) % NUM_VC;
                end
            end
            checkOutput("out_v", out_v, mon_any);
            if (mon_any && out_v) begin
                checkOutput("out_vc", out_vc, mon_sel);
                checkOutput("out_x", out_x, sb[mon_sel][0].x);
                checkOutput("out_y", out_y, sb[mon_sel][0].y);
                checkOutput("out_data", out_data, sb[mon_sel][0].data);
            end
            pend_pop = mon_any;
            pend_vc  = mon_sel;
            checkOutput("err_ovf", err_ovf, m_err);
            checkOutput("done", done, m_done);
        end
    end

    // Reference model update at each clock edge: completion flag, pop of the granted flit, then push or drop of the offered flit.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                sb[v].delete();
            end
            m_rr   = 0;
            m_pops = 0;
            m_err  = 0;
            m_done = 0;
        end else begin
            cm_empty = 1;
            for (int v = 0; v < NUM_VC; v++) begin
                if (sb[v].size() != 0) cm_empty = 0;
            end
            if (m_pops == N_PACKETS && cm_empty) m_done = 1;
            cm_drop = in_v && (sb[in_vc].size() == DEPTH);
            if (pend_pop) begin
                sb[pend_vc].delete(0);
                m_rr = (pend_vc + 1) % NUM_VC;
                m_pops++;
            end
            if (in_v) begin
                if (cm_drop) m_err = 1;
                else sb[in_vc].push_back(mkFlit(in_x, in_y, in_data));
            end
        end
    end

    task automatic applyStimulus(input bit v, input int vc, input flit_t f, input logic [NUM_VC-1:0] ob);
        in_v    = v;
        in_vc   = VC_W'(vc);
        in_x    = f.x;
        in_y    = f.y;
        in_data = f.data;
        out_b   = ob;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [NUM_VC-1:0] ob);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, ob);
    endtask

    task automatic doReset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(input int budget);
        int  n;
        bit  empty;
        n = 0;
        empty = 0;
        while (!empty && n < budget) begin
            empty = 1;
            for (int v = 0; v < NUM_VC; v++) begin
                if (sb[v].size() != 0) empty = 0;
            end
            if (!empty) begin
                applyStimulus(0, 0, '0, '0);
                n++;
            end
        end
        checkOutput("drain within budget", empty, 1);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // A single flit on VC1 is checked by the monitor one cycle after it is pushed.
        applyStimulus(1, 1, mkFlit(2, 3, 'hAB), '0);
        idle(2, '0);

        // Five pushes to VC0 while its output is blocked: the fifth is dropped and sets err_ovf.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, randFlit(), '1);
        idle(1, '1);
        checkOutput("err_ovf after overflow", err_ovf, 1);
        drain(50);
        checkOutput("err_ovf sticky", err_ovf, 1);

        // Fairness: three flits on each VC, released together after a reset.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, i % 2, randFlit(), '1);
        drain(50);

        // Per-VC blocking: only VC1 may drain while VC0 stays blocked.
        for (int i = 0; i < 4; i++) applyStimulus(1, i % 2, randFlit(), '1);
        idle(4, 2'b01);
        drain(50);

        // Reset while two flits are still queued.
        applyStimulus(1, 0, randFlit(), '1);
        applyStimulus(1, 1, randFlit(), '1);
        #1 rst = 1'b0;
        #1 checkOutput("out_v in mid reset", out_v, 0);
        checkOutput("in_b in mid reset", in_b, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(3, '0);

        // Completion: eight flits pass one at a time, then a ninth flit must not clear done.
        for (int i = 0; i < N_PACKETS; i++) begin
            applyStimulus(1, $urandom_range(0, NUM_VC - 1), randFlit(), '0);
            idle(2, '0);
        end
        idle(1, '0);
        checkOutput("done after N_PACKETS", done, 1);
        applyStimulus(1, 0, randFlit(), '0);
        idle(3, '0);
        checkOutput("done sticky", done, 1);

        // Random traffic with random per-VC backpressure.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, NUM_VC - 1), randFlit(),
                          NUM_VC'($urandom_range(0, (1 << NUM_VC) - 1) & $urandom_range(0, (1 << NUM_VC) - 1)));
        end
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/torus_vc_port.md
TORUS_VC_PORT -- requirements
Module: torus_vc_port

Interface
REQ-001 SHALL have parameter X_W, default 2: destination x-address width.
REQ-002 SHALL have parameter Y_W, default 2: destination y-address width.
REQ-003 SHALL have parameter D_W, default 256: payload width.
REQ-004 SHALL have parameter VC_W, default 1: virtual-channel index width; NUM_VC = 1<<VC_W.
REQ-005 SHALL have parameter DEPTH, default 4: per-VC FIFO depth; power of two, at least 2.
REQ-006 SHALL have parameter N_PACKETS, default 128: packets expected to leave before done.
REQ-007 SHALL have these ports, in this order:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_v  input  1  input flit valid.
- in_vc  input  VC_W  target VC of input flit.
- in_x, in_y, in_data  input  X_W/Y_W/D_W  flit fields.
- in_b  output  NUM_VC  per-VC backpressure to upstream.
- out_v  output  1  output flit valid.
- out_vc  output  VC_W  VC of output flit.
- out_x, out_y, out_data  output  X_W/Y_W/D_W  output flit fields.
- out_b  input  NUM_VC  per-VC backpressure from downstream.
- err_ovf  output  1  sticky overflow error.
- done  output  1  sticky completion flag.

Function
REQ-008 SHALL keep one FIFO per VC, DEPTH entries of {x,y,data}, with registered read/write pointers and a count of width clog2(DEPTH)+1.
REQ-009 SHALL drive in_b[v] combinationally high exactly when count[v]==DEPTH.
REQ-010 SHALL push flit into FIFO in_vc on a rising edge where in_v=1 and in_b[in_vc]=0.
REQ-011 SHALL drop a flit offered with in_v=1 and in_b[in_vc]=1, and set err_ovf the next cycle; err_ovf stays set until reset.
REQ-012 SHALL define VC v as eligible when count[v]>0 and out_b[v]=0.
REQ-013 SHALL select the output VC combinationally by round-robin over eligible VCs, starting at rr_ptr and wrapping from NUM_VC-1 to 0.
REQ-014 SHALL drive out_v=1 when any VC is eligible, with out_vc and the fields taken from the selected FIFO head; otherwise out_v=0 and the fields are don't-care.
REQ-015 SHALL pop the selected FIFO on every rising edge where out_v=1, and then set rr_ptr to the selected VC+1 modulo NUM_VC; with no pop, rr_ptr holds.
REQ-016 SHALL have a minimum latency of one cycle: a flit pushed at edge N can appear on out at earliest in the cycle after edge N; there is no input-to-output bypass.
REQ-017 SHALL, on a simultaneous push and pop of the same VC, leave its count unchanged and apply both pointer updates; push and pop on different VCs are independent.
REQ-018 SHALL wrap pointers modulo DEPTH; every flit on a given VC leaves in arrival order.
REQ-019 SHALL count pops in a saturating counter of width clog2(N_PACKETS)+1.
REQ-020 SHALL set done on the edge where pops==N_PACKETS and all counts are 0; done stays set until reset.
REQ-021 SHALL keep out_b changes within a cycle from affecting state already registered, because the output path is combinational from registers and out_b.

Reset
REQ-022 SHALL, when rst=0 at any time (including mid-transfer), asynchronously clear all pointers, counts, rr_ptr, the pop counter, err_ovf and done, and discard FIFO contents.
REQ-023 SHALL, while in reset, hold out_v=0, in_b all 0, err_ovf=0 and done=0; storage arrays need no reset.
REQ-024 SHALL accept a flit on the first rising edge after rst rises.

Verification
REQ-025 SHALL cover a single flit: VC_W=1, push VC1 x=2 y=3 data=0xAB at edge 0 -> next cycle out_v=1, out_vc=1, x=2, y=3, data=0xAB; count returns to 0 after the pop.
REQ-026 SHALL cover fill and overflow: DEPTH=4, out_b=all 1, 5 pushes to VC0 -> in_b[0]=1 after the 4th push; the 5th push is dropped and err_ovf=1; after release, exactly 4 flits emerge in order.
REQ-027 SHALL cover fairness: both VCs hold 3 flits and out_b=0 -> output VC sequence 0,1,0,1,0,1.
REQ-028 SHALL cover per-VC blocking: out_b[0]=1, both VCs loaded -> only VC1 flits emerge; VC0 resumes the cycle after out_b[0] drops.
REQ-029 SHALL cover completion: N_PACKETS=8, 8 flits pass -> done=1 the edge after the last pop; a 9th flit does not clear done.
REQ-030 SHALL cover reset mid-operation: rst=0 with 2 flits queued -> out_v=0 immediately; after release, out_v=0 and counts are 0.
